// File: rtl/rab_lookup_stage_if.sv
// Bus bundle for one RAB lookup channel: upstream request, slice compare
// interface, translated-request output and error-record output.
interface rab_lookup_stage_if #(
   parameter int N_SLICES = 4,
   parameter int ID_WIDTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              in_addr;
   logic [7:0]               in_len;
   logic [2:0]               in_size;
   logic [ID_WIDTH-1:0]      in_id;
   logic                     in_trans_type;

   logic [31:0]              slc_addr_min;
   logic [31:0]              slc_addr_max;
   logic                     slc_trans_type;
   logic [N_SLICES-1:0]      slc_hit;
   logic [N_SLICES-1:0]      slc_prot;
   logic [32*N_SLICES-1:0]   slc_addr;

   logic                     m_valid;
   logic                     m_ready;
   logic [31:0]              m_addr;
   logic [7:0]               m_len;
   logic [2:0]               m_size;
   logic [ID_WIDTH-1:0]      m_id;

   logic                     err_valid;
   logic                     err_ready;
   logic [1:0]               err_type;
   logic [31:0]              err_addr;
   logic [ID_WIDTH-1:0]      err_id;

   logic                     multi_hit;

   // Lookup stage side
   modport slave (
      input  in_valid, in_addr, in_len, in_size, in_id, in_trans_type,
      output in_ready,
      output slc_addr_min, slc_addr_max, slc_trans_type,
      input  slc_hit, slc_prot, slc_addr,
      output m_valid, m_addr, m_len, m_size, m_id,
      input  m_ready,
      output err_valid, err_type, err_addr, err_id,
      input  err_ready,
      output multi_hit
   );

   // Environment side (requester, slices, consumers)
   modport master (
      output in_valid, in_addr, in_len, in_size, in_id, in_trans_type,
      input  in_ready,
      input  slc_addr_min, slc_addr_max, slc_trans_type,
      output slc_hit, slc_prot, slc_addr,
      input  m_valid, m_addr, m_len, m_size, m_id,
      output m_ready,
      input  err_valid, err_type, err_addr, err_id,
      output err_ready,
      input  multi_hit
   );
endinterface

// File: rtl/rab_lookup_stage.sv
// Per-channel RAB address-request front end: latches a burst, drives the
// compare slices with its first/last byte address, picks the lowest hitting
// slice and forwards the translated request or emits an error record.
module rab_lookup_stage #(
   parameter int N_SLICES = 4,
   parameter int ID_WIDTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   rab_lookup_stage_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOOKUP, FWD, ERR} state_t;

   state_t              state, state_nxt;

   logic [31:0]         addr_q;
   logic [31:0]         max_q;
   logic                ovf_q;
   logic                tt_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [31:0]         m_addr_q;
   logic [1:0]          err_type_q;
   logic                multi_q;

   logic                accept;
   logic [15:0]         span;
   logic [32:0]         end_addr;

   logic                any_hit;
   logic                multi;
   logic                sel_prot;
   logic [31:0]         sel_addr;
   logic                fail;

   assign accept   = (state == IDLE) && bus.in_valid;
   assign span     = 16'(({8'h00, bus.in_len} + 16'd1) << bus.in_size);
   assign end_addr = {1'b0, bus.in_addr} + {17'h0_0000, span} - 33'd1;
   assign fail     = ovf_q || !any_hit || sel_prot;

   // Priority select of the lowest hitting slice, plus multiple-hit detect
   always_comb begin
      any_hit  = 1'b0;
      multi    = 1'b0;
      sel_prot = 1'b0;
      sel_addr = '0;
      for (int unsigned i = 0; i < N_SLICES; i++) begin
         if (bus.slc_hit[i]) begin
            if (!any_hit) begin
               any_hit  = 1'b1;
               sel_prot = bus.slc_prot[i];
               sel_addr = bus.slc_addr[32*i +: 32];
            end else begin
               multi = 1'b1;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = fail ? ERR : FWD;
         FWD:     if (bus.m_ready) state_nxt = IDLE;
         ERR:     if (bus.err_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture and lookup result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         max_q      <= '0;
         ovf_q      <= 1'b0;
         tt_q       <= 1'b0;
         len_q      <= '0;
         size_q     <= '0;
         id_q       <= '0;
         m_addr_q   <= '0;
         err_type_q <= '0;
         multi_q    <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= bus.in_addr;
            max_q  <= end_addr[31:0];
            ovf_q  <= end_addr[32];
            tt_q   <= bus.in_trans_type;
            len_q  <= bus.in_len;
            size_q <= bus.in_size;
            id_q   <= bus.in_id;
         end
         multi_q <= (state == LOOKUP) && multi;
         if (state == LOOKUP) begin
            if (ovf_q)         err_type_q <= 2'b11;
            else if (!any_hit) err_type_q <= 2'b01;
            else if (sel_prot) err_type_q <= 2'b10;
            else               m_addr_q   <= sel_addr;
         end
      end
   end

   // Output drive; in_ready is gated by reset so it stays low while held
   always_comb begin
      bus.in_ready       = (state == IDLE) && rst_n;
      bus.slc_addr_min   = addr_q;
      bus.slc_addr_max   = max_q;
      bus.slc_trans_type = tt_q;
      bus.m_valid        = (state == FWD);
      bus.m_addr         = m_addr_q;
      bus.m_len          = len_q;
      bus.m_size         = size_q;
      bus.m_id           = id_q;
      bus.err_valid      = (state == ERR);
      bus.err_type       = err_type_q;
      bus.err_addr       = addr_q;
      bus.err_id         = id_q;
      bus.multi_hit      = multi_q;
   end

endmodule

// File: tb/tb_rab_lookup_stage.sv
// Directed bench for rab_lookup_stage with a small behavioural slice model.
module tb_rab_lookup_stage;

   localparam int NS = 4;
   localparam int IW = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rab_lookup_stage_if #(.N_SLICES(NS), .ID_WIDTH(IW)) bus ();

   rab_lookup_stage #(.N_SLICES(NS), .ID_WIDTH(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Slice windows: hit when the whole burst fits, translate by offset
   logic [31:0] win_lo  [NS];
   logic [31:0] win_hi  [NS];
   logic [31:0] win_off [NS];
   logic        win_pw  [NS];
   logic [NS-1:0] force_hit;

   always_comb begin
      bus.slc_hit  = '0;
      bus.slc_prot = '0;
      bus.slc_addr = '0;
      for (int i = 0; i < NS; i++) begin
         bus.slc_hit[i] = force_hit[i] ||
                          (bus.slc_addr_min >= win_lo[i] && bus.slc_addr_max <= win_hi[i]);
         bus.slc_prot[i] = bus.slc_hit[i] && bus.slc_trans_type && win_pw[i];
         bus.slc_addr[32*i +: 32] = bus.slc_addr_min - win_lo[i] + win_off[i];
      end
   end

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request and return one tick after its accepting edge
   task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [IW-1:0] id, input logic tt);
      @(negedge clk);
      bus.in_addr       = a;
      bus.in_len        = l;
      bus.in_size       = s;
      bus.in_id         = id;
      bus.in_trans_type = tt;
      bus.in_valid      = 1'b1;
      check("accept_rdy", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      check("lookup_rdy", 64'(bus.in_ready), 64'd0);
      check("lookup_mv",  64'(bus.m_valid),  64'd0);
      check("lookup_ev",  64'(bus.err_valid), 64'd0);
   endtask

   task automatic drain_fwd();
      bus.m_ready = 1'b1;
      step();
      bus.m_ready = 1'b0;
      check("idle_rdy", 64'(bus.in_ready), 64'd1);
      check("idle_mv",  64'(bus.m_valid),  64'd0);
   endtask

   task automatic drain_err();
      bus.err_ready = 1'b1;
      step();
      bus.err_ready = 1'b0;
      check("idle_rdy_e", 64'(bus.in_ready),  64'd1);
      check("idle_ev",    64'(bus.err_valid), 64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk = 1'b0;
      rst_n = 1'b0;
      force_hit = '0;
      win_lo[0] = 32'h1000_0000; win_hi[0] = 32'h1FFF_FFFF; win_off[0] = 32'h8000_0000; win_pw[0] = 1'b0;
      win_lo[1] = 32'h3000_0000; win_hi[1] = 32'h3FFF_FFFF; win_off[1] = 32'hA000_0000; win_pw[1] = 1'b0;
      win_lo[2] = 32'h2000_0000; win_hi[2] = 32'h2FFF_FFFF; win_off[2] = 32'h6000_0000; win_pw[2] = 1'b1;
      win_lo[3] = 32'h3000_0000; win_hi[3] = 32'h3FFF_FFFF; win_off[3] = 32'hC000_0000; win_pw[3] = 1'b0;
      bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_len = '0; bus.in_size = '0;
      bus.in_id = '0; bus.in_trans_type = 1'b0; bus.m_ready = 1'b0; bus.err_ready = 1'b0;

      // Reset state
      #12;
      check("rst_rdy",   64'(bus.in_ready),     64'd0);
      check("rst_mv",    64'(bus.m_valid),      64'd0);
      check("rst_ev",    64'(bus.err_valid),    64'd0);
      check("rst_multi", 64'(bus.multi_hit),    64'd0);
      check("rst_max",   64'(bus.slc_addr_max), 64'd0);
      check("rst_maddr", 64'(bus.m_addr),       64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_rdy", 64'(bus.in_ready), 64'd1);

      // Read through slice 0
      send(32'h1000_0040, 8'd3, 3'd2, 4'd9, 1'b0);
      check("t1_max", 64'(bus.slc_addr_max),   64'h1000_004F);
      check("t1_tt",  64'(bus.slc_trans_type), 64'd0);
      step();
      check("t1_mv",    64'(bus.m_valid),   64'd1);
      check("t1_ev",    64'(bus.err_valid), 64'd0);
      check("t1_maddr", 64'(bus.m_addr),    64'h8000_0040);
      check("t1_len",   64'(bus.m_len),     64'd3);
      check("t1_size",  64'(bus.m_size),    64'd2);
      check("t1_id",    64'(bus.m_id),      64'd9);
      check("t1_multi", 64'(bus.multi_hit), 64'd0);
      drain_fwd();

      // Miss
      send(32'h4000_0000, 8'd0, 3'd0, 4'd5, 1'b0);
      step();
      check("t2_ev",    64'(bus.err_valid), 64'd1);
      check("t2_mv",    64'(bus.m_valid),   64'd0);
      check("t2_type",  64'(bus.err_type),  64'd1);
      check("t2_eaddr", 64'(bus.err_addr),  64'h4000_0000);
      check("t2_eid",   64'(bus.err_id),    64'd5);
      drain_err();

      // Slices 1 and 3 both hit: lowest wins, one-cycle multi_hit
      send(32'h3000_0100, 8'd0, 3'd0, 4'd2, 1'b0);
      step();
      check("t3_maddr", 64'(bus.m_addr),    64'hA000_0100);
      check("t3_multi", 64'(bus.multi_hit), 64'd1);
      step();
      check("t3_multi_end", 64'(bus.multi_hit), 64'd0);
      check("t3_mv_hold",   64'(bus.m_valid),   64'd1);
      drain_fwd();

      // Write protection violation, then read on the same window
      send(32'h2000_0000, 8'd1, 3'd3, 4'd7, 1'b1);
      check("t4_max", 64'(bus.slc_addr_max),   64'h2000_000F);
      check("t4_tt",  64'(bus.slc_trans_type), 64'd1);
      step();
      check("t4_ev",   64'(bus.err_valid), 64'd1);
      check("t4_type", 64'(bus.err_type),  64'd2);
      drain_err();
      send(32'h2000_0000, 8'd1, 3'd3, 4'd7, 1'b0);
      step();
      check("t4r_mv",    64'(bus.m_valid), 64'd1);
      check("t4r_maddr", 64'(bus.m_addr),  64'h6000_0000);
      drain_fwd();

      // End address past 32 bits wins over a slice hit
      force_hit = 4'b0001;
      send(32'hFFFF_FFF0, 8'd7, 3'd2, 4'd3, 1'b0);
      check("t5_max", 64'(bus.slc_addr_max), 64'h0000_000F);
      step();
      force_hit = '0;
      check("t5_ev",   64'(bus.err_valid), 64'd1);
      check("t5_mv",   64'(bus.m_valid),   64'd0);
      check("t5_type", 64'(bus.err_type),  64'd3);
      check("t5_eid",  64'(bus.err_id),    64'd3);
      drain_err();

      // Largest span: 256 beats of 128 bytes
      send(32'h1000_0000, 8'd255, 3'd7, 4'd1, 1'b0);
      check("t6_max", 64'(bus.slc_addr_max), 64'h1000_7FFF);
      step();
      check("t6_maddr", 64'(bus.m_addr), 64'h8000_0000);
      check("t6_len",   64'(bus.m_len),  64'd255);
      drain_fwd();

      // Backpressure then reset during FWD
      send(32'h1000_0080, 8'd0, 3'd2, 4'd4, 1'b0);
      step();
      for (int i = 0; i < 5; i++) begin
         check("bp_mv",    64'(bus.m_valid),  64'd1);
         check("bp_maddr", 64'(bus.m_addr),   64'h8000_0080);
         check("bp_rdy",   64'(bus.in_ready), 64'd0);
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_mv",    64'(bus.m_valid),  64'd0);
      check("ar_rdy",   64'(bus.in_ready), 64'd0);
      check("ar_maddr", 64'(bus.m_addr),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ar_rel_rdy", 64'(bus.in_ready), 64'd1);
      step();
      check("ar_idle_rdy", 64'(bus.in_ready), 64'd1);
      check("ar_idle_mv",  64'(bus.m_valid),  64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
